// File: rtl/ld3320_asr_loader_if.sv
`default_nettype none
// ld3320_asr_loader_if: handshake bundle between the ASR phrase loader and the
// shared LD3320 bus engine / delay counter.  Rev 1.0
interface ld3320_asr_loader_if;
  logic       bus_ena;
  logic       bus_sel;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_done;
  logic       dly_ena;
  logic [7:0] dly_div;
  logic       dly_done;

  modport master (
    output bus_ena, bus_sel, bus_addr, bus_wdata, dly_ena, dly_div,
    input  bus_rdata, bus_done, dly_done
  );

  modport slave (
    input  bus_ena, bus_sel, bus_addr, bus_wdata, dly_ena, dly_div,
    output bus_rdata, bus_done, dly_done
  );
endinterface
`default_nettype wire

// File: rtl/ld3320_asr_loader.sv
`default_nettype none
// ld3320_asr_loader: loads NUM_PHRASES pinyin keyword records from a ROM into
// the LD3320 recognition list via the shared bus engine and delay counter.  Rev 1.0
module ld3320_asr_loader #(
  parameter int         NUM_PHRASES = 4,
  parameter int         MAX_LEN     = 32,
  parameter int         ROM_AW      = 8,
  parameter int         POLL_LIMIT  = 200,
  parameter logic [7:0] DLY_DIV     = 8'd3
) (
  input  wire               clk,
  input  wire               sys_rst,
  input  wire               start,
  output logic [ROM_AW-1:0] rom_addr,
  input  wire  [7:0]        rom_data,
  ld3320_asr_loader_if.master bif,
  output logic [7:0]        phrase_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [7:0]        MAX_LEN_B    = 8'(MAX_LEN);
  localparam logic [7:0]        POLL_LIMIT_B = 8'(POLL_LIMIT);
  localparam logic [7:0]        LAST_IDX     = 8'(NUM_PHRASES - 1);
  localparam logic [ROM_AW-1:0] ROM_ONE      = ROM_AW'(1);

  typedef enum logic [4:0] {
    S_IDLE, S_LEN_WAIT, S_LEN_CHK, S_POLL, S_POLL_WT,
    S_W_C1, S_W_C3, S_W_08A, S_W_08B,
    S_CH_ADDR, S_CH_WAIT, S_CH_WR,
    S_W_B9, S_W_B2, S_W_37,
    S_BUS_WT, S_DLY, S_NEXT, S_FIN, S_ERR
  } state_t;

  state_t     state;
  state_t     ret_state;
  logic       wait_after;
  logic [7:0] len;
  logic [7:0] char_cnt;
  logic [7:0] poll_cnt;
  logic [7:0] poll_next;

  logic       bus_ena;
  logic       bus_sel;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       dly_ena;
  logic [7:0] dly_div;

  assign bif.bus_ena   = bus_ena;
  assign bif.bus_sel   = bus_sel;
  assign bif.bus_addr  = bus_addr;
  assign bif.bus_wdata = bus_wdata;
  assign bif.dly_ena   = dly_ena;
  assign bif.dly_div   = dly_div;

  assign poll_next = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;

  // Write states launch one transaction and park in S_BUS_WT; ret_state and
  // wait_after tell S_BUS_WT where to go and whether a delay precedes it.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      wait_after <= 1'b0;
      len        <= '0;
      char_cnt   <= '0;
      poll_cnt   <= '0;
      bus_ena    <= 1'b0;
      bus_sel    <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      dly_ena    <= 1'b0;
      dly_div    <= '0;
      rom_addr   <= '0;
      phrase_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      bus_ena <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          error      <= 1'b0;
          phrase_idx <= '0;
          rom_addr   <= '0;
          poll_cnt   <= '0;
          busy       <= 1'b1;
          state      <= S_LEN_WAIT;
        end
        S_LEN_WAIT: state <= S_LEN_CHK;
        S_LEN_CHK: begin
          len      <= rom_data;
          char_cnt <= '0;
          if (rom_data == 8'd0 || rom_data > MAX_LEN_B) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            state <= S_POLL;
          end
        end
        S_POLL: begin
          bus_ena   <= 1'b1;
          bus_sel   <= 1'b0;
          bus_addr  <= 8'hB2;
          bus_wdata <= 8'h00;
          state     <= S_POLL_WT;
        end
        S_POLL_WT: if (bif.bus_done) begin
          if (bif.bus_rdata == 8'h21) begin
            state <= S_W_C1;
          end else begin
            poll_cnt <= poll_next;
            if (poll_next >= POLL_LIMIT_B) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else begin
              dly_ena   <= 1'b1;
              dly_div   <= DLY_DIV;
              ret_state <= S_POLL;
              state     <= S_DLY;
            end
          end
        end
        S_W_C1: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'hC1; bus_wdata <= phrase_idx;
          wait_after <= 1'b0; ret_state <= S_W_C3; state <= S_BUS_WT;
        end
        S_W_C3: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'hC3; bus_wdata <= 8'h00;
          wait_after <= 1'b0; ret_state <= S_W_08A; state <= S_BUS_WT;
        end
        S_W_08A: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'h08; bus_wdata <= 8'h04;
          wait_after <= 1'b1; ret_state <= S_W_08B; state <= S_BUS_WT;
        end
        S_W_08B: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'h08; bus_wdata <= 8'h00;
          wait_after <= 1'b1; ret_state <= S_CH_ADDR; state <= S_BUS_WT;
        end
        // rom_addr sits on the length byte (or the previous pinyin byte), so
        // each character first steps the address, then waits out the ROM latency.
        S_CH_ADDR: begin
          rom_addr <= rom_addr + ROM_ONE;
          state    <= S_CH_WAIT;
        end
        S_CH_WAIT: state <= S_CH_WR;
        S_CH_WR: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'h05; bus_wdata <= rom_data;
          char_cnt   <= char_cnt + 8'd1;
          wait_after <= 1'b0;
          ret_state  <= (char_cnt + 8'd1 == len) ? S_W_B9 : S_CH_ADDR;
          state      <= S_BUS_WT;
        end
        S_W_B9: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'hB9; bus_wdata <= len;
          wait_after <= 1'b0; ret_state <= S_W_B2; state <= S_BUS_WT;
        end
        S_W_B2: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'hB2; bus_wdata <= 8'hFF;
          wait_after <= 1'b0; ret_state <= S_W_37; state <= S_BUS_WT;
        end
        S_W_37: begin
          bus_ena <= 1'b1; bus_sel <= 1'b1; bus_addr <= 8'h37; bus_wdata <= 8'h04;
          wait_after <= 1'b0; ret_state <= S_NEXT; state <= S_BUS_WT;
        end
        S_BUS_WT: if (bif.bus_done) begin
          if (wait_after) begin
            dly_ena <= 1'b1;
            dly_div <= DLY_DIV;
            state   <= S_DLY;
          end else begin
            state <= ret_state;
          end
        end
        S_DLY: if (bif.dly_done) begin
          dly_ena <= 1'b0;
          state   <= ret_state;
        end
        // done/busy are updated on entry to S_FIN so a start coinciding with
        // the done pulse still lands outside S_IDLE.
        S_NEXT: begin
          rom_addr   <= rom_addr + ROM_ONE;
          phrase_idx <= phrase_idx + 8'd1;
          poll_cnt   <= '0;
          if (phrase_idx == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            state <= S_LEN_WAIT;
          end
        end
        S_FIN:   state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ld3320_asr_loader.sv
`default_nettype none
// tb_ld3320_asr_loader: scoreboard bench with ROM, bus-engine and delay models.
module tb_ld3320_asr_loader;
  localparam int NP   = 2;
  localparam int PLIM = 200;

  logic       clk     = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] phrase_idx;
  logic       busy, done, error;
  logic [7:0] rom [0:255];

  int          n_vec = 0, n_miss = 0;
  int          n_ena = 0, n_dly = 0, n_done = 0;
  logic [7:0]  last_addr = 8'h00;
  int          poll_busy_left = 0;
  bit          always_busy = 1'b0;
  bit          spurious_en = 1'b1;
  bit          bus_out = 1'b0;
  logic [16:0] exp_q[$];

  ld3320_asr_loader_if bif();

  ld3320_asr_loader #(
    .NUM_PHRASES(NP), .MAX_LEN(32), .ROM_AW(8), .POLL_LIMIT(PLIM), .DLY_DIV(8'd3)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data), .bif(bif),
    .phrase_idx(phrase_idx), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) if (!sys_rst && done) n_done++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus engine: random 1..20 cycle latency, 0x00 on busy polls, spurious
  // done pulses while the loader is idle.
  initial begin : bus_model
    int          ncyc, last_done, bwait;
    bit          was_out;
    logic [16:0] cap, cur, want;
    ncyc = 0; last_done = 0; bwait = 0; cap = '0;
    bif.bus_done = 1'b0; bif.bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      ncyc++;
      bif.bus_done = 1'b0;
      if (sys_rst) begin
        bus_out = 1'b0;
      end else begin
        was_out = bus_out;
        if (was_out) begin
          if (bwait == 0) begin
            check("bus_hold", 64'({bif.bus_sel, bif.bus_addr, bif.bus_wdata}), 64'(cap));
            bif.bus_done  = 1'b1;
            bus_out       = 1'b0;
            last_done     = ncyc;
            bif.bus_rdata = 8'h21;
            if (!cap[16] && cap[15:8] == 8'hB2 && (always_busy || poll_busy_left > 0)) begin
              bif.bus_rdata = 8'h00;
              if (poll_busy_left > 0) poll_busy_left--;
            end
          end else begin
            bwait--;
          end
        end else if (spurious_en && !busy && !bif.bus_ena && $urandom_range(0, 3) == 0) begin
          bif.bus_done = 1'b1;
        end
        if (bif.bus_ena) begin
          cur = {bif.bus_sel, bif.bus_addr, bif.bus_wdata};
          n_ena++;
          last_addr = bif.bus_addr;
          check("one_outstanding", 64'(was_out), 64'd0);
          check("ena_gap", 64'(ncyc - last_done >= 2), 64'd1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("txn", 64'(want[16] ? cur : {cur[16:8], want[7:0]}), 64'(want));
          end else begin
            check("txn_extra", 64'(cur), 64'h1FFFF);
          end
          cap     = cur;
          bus_out = 1'b1;
          bwait   = $urandom_range(0, 19);
        end
      end
    end
  end

  initial begin : dly_model
    bit prev, pulsed, active;
    int dcnt;
    prev = 1'b0; pulsed = 1'b0; active = 1'b0; dcnt = 0;
    bif.dly_done = 1'b0;
    forever begin
      @(negedge clk);
      bif.dly_done = 1'b0;
      if (sys_rst) begin
        prev = 1'b0; pulsed = 1'b0; active = 1'b0;
      end else begin
        if (prev) check("dly_hold", 64'(bif.dly_ena), 64'(!pulsed));
        if (pulsed) begin
          pulsed = 1'b0;
          active = 1'b0;
        end else if (bif.dly_ena) begin
          if (!active) begin
            active = 1'b1;
            n_dly++;
            check("dly_div", 64'(bif.dly_div), 64'd3);
            dcnt = $urandom_range(0, 3);
          end
          if (dcnt == 0) begin
            bif.dly_done = 1'b1;
            pulsed       = 1'b1;
          end else begin
            dcnt--;
          end
        end
        prev = bif.dly_ena;
      end
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_phrase(input logic [7:0] idx, input int base, input int nbusy);
    int len;
    len = int'(rom[base]);
    for (int i = 0; i <= nbusy; i++) exp_q.push_back({1'b0, 8'hB2, 8'h00});
    push_wr(8'hC1, idx);
    push_wr(8'hC3, 8'h00);
    push_wr(8'h08, 8'h04);
    push_wr(8'h08, 8'h00);
    for (int k = 0; k < len; k++) push_wr(8'h05, rom[base + 1 + k]);
    push_wr(8'hB9, 8'(len));
    push_wr(8'hB2, 8'hFF);
    push_wr(8'h37, 8'h04);
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({rom_addr, bif.bus_ena, bif.bus_sel, bif.bus_addr, bif.bus_wdata,
                    bif.dly_ena, bif.dly_div, phrase_idx, busy, done, error}), 64'd0);
  endtask

  task automatic run_load(input string tag, input int exp_dly, input bit exp_err,
                          input int again_at);
    bit hit;
    int n_before;
    hit = 1'b0;
    n_ena = 0; n_dly = 0; n_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    check({tag, "_start_state"}, 64'({rom_addr, phrase_idx, error}), 64'd0);
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk);
      if (done || error) hit = 1'b1;
      else start = (c == again_at);
    end
    start = 1'b0;
    check({tag, "_finished"}, 64'(hit), 64'd1);
    check({tag, "_end_flags"}, 64'({busy, done, error}), 64'({1'b0, !exp_err, exp_err}));
    n_before = n_ena;
    repeat (30) @(negedge clk);
    check({tag, "_quiet_bus"}, 64'(n_ena), 64'(n_before));
    check({tag, "_idle_flags"}, 64'({busy, done, error}), 64'({2'b00, exp_err}));
    check({tag, "_done_cnt"}, 64'(n_done), 64'(exp_err ? 0 : 1));
    check({tag, "_dly_cnt"}, 64'(n_dly), 64'(exp_dly));
    check({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'd3; rom[1] = "a"; rom[2] = "b"; rom[3] = "c";
    rom[4] = 8'd2; rom[5] = "x"; rom[6] = "y";

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    sys_rst = 1'b0;
    repeat (5) @(negedge clk);

    push_phrase(8'd0, 0, 0);
    push_phrase(8'd1, 4, 0);
    run_load("nominal", 4, 1'b0, -1);
    check("nominal_phrase_idx", 64'(phrase_idx), 64'(NP));

    poll_busy_left = 5;
    push_phrase(8'd0, 0, 5);
    push_phrase(8'd1, 4, 0);
    run_load("busy_poll", 9, 1'b0, 40);

    always_busy = 1'b1;
    for (int i = 0; i < PLIM; i++) exp_q.push_back({1'b0, 8'hB2, 8'h00});
    run_load("poll_timeout", PLIM - 1, 1'b1, -1);
    check("poll_timeout_reads", 64'(n_ena), 64'(PLIM));
    always_busy = 1'b0;

    rom[0] = 8'd0;
    run_load("len_zero", 0, 1'b1, -1);
    check("len_zero_txns", 64'(n_ena), 64'd0);
    rom[0] = 8'd33;
    run_load("len_long", 0, 1'b1, -1);
    check("len_long_txns", 64'(n_ena), 64'd0);
    rom[0] = 8'd3;

    push_phrase(8'd0, 0, 0);
    push_phrase(8'd1, 4, 0);
    last_addr = 8'h00;
    hit = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge clk);
      if (last_addr == 8'h05) hit = 1'b1;
    end
    check("rst_reached_chars", 64'(last_addr), 64'h05);
    sys_rst = 1'b1;
    @(negedge clk);
    check_zero("midrun_reset");
    start = 1'b1;
    @(negedge clk);
    check_zero("reset_beats_start");
    start = 1'b0; sys_rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_reset_idle", 64'({busy, done, error}), 64'd0);

    push_phrase(8'd0, 0, 0);
    push_phrase(8'd1, 4, 0);
    run_load("reload", 4, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
